// File: rtl/radial_zoom_filter.sv
`default_nettype none
// ============================================================================
// Module   : radial_zoom_filter
// Brief    : Circular magnifier; zooms frame-buffer pixels inside a circle.
// Revision : 1.0 - initial release
// ============================================================================
module radial_zoom_filter #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int FB_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_valid_in,
  input  logic [9:0]            x_local,
  input  logic [9:0]            y_local,
  input  logic [15:0]           rgb565_in,
  input  logic                  filter_en,
  input  logic [9:0]            cfg_center_x,
  input  logic [9:0]            cfg_center_y,
  input  logic [7:0]            cfg_radius,
  input  logic [1:0]            cfg_zoom_shift,
  input  logic [1:0]            cfg_outside_mode,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_en,
  input  logic [15:0]           frame_buffer_data,
  output logic                  pixel_valid_out,
  output logic [15:0]           rgb565_out
);

  localparam logic [9:0] c_CX_DEF = 10'(IMG_WIDTH / 2);
  localparam logic [9:0] c_CY_DEF = 10'(IMG_HEIGHT / 2);
  localparam int         c_LAST   = FB_LATENCY - 1;

  // Shadow configuration
  logic       r_sh_en;
  logic [9:0] r_sh_cx, r_sh_cy;
  logic [7:0] r_sh_rad;
  logic [1:0] r_sh_shift, r_sh_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_en    <= 1'b0;
      r_sh_cx    <= c_CX_DEF;
      r_sh_cy    <= c_CY_DEF;
      r_sh_rad   <= 8'd50;
      r_sh_shift <= 2'd1;
      r_sh_mode  <= 2'd0;
    end else if (frame_start) begin
      r_sh_en    <= filter_en;
      r_sh_cx    <= cfg_center_x;
      r_sh_cy    <= cfg_center_y;
      r_sh_rad   <= cfg_radius;
      r_sh_shift <= cfg_zoom_shift;
      r_sh_mode  <= cfg_outside_mode;
    end
  end

  // A pixel arriving with frame_start already sees the new configuration
  logic       w_en;
  logic [9:0] w_cx, w_cy;
  logic [7:0] w_rad;
  logic [1:0] w_shift, w_mode;

  assign w_en    = frame_start ? filter_en        : r_sh_en;
  assign w_cx    = frame_start ? cfg_center_x     : r_sh_cx;
  assign w_cy    = frame_start ? cfg_center_y     : r_sh_cy;
  assign w_rad   = frame_start ? cfg_radius       : r_sh_rad;
  assign w_shift = frame_start ? cfg_zoom_shift   : r_sh_shift;
  assign w_mode  = frame_start ? cfg_outside_mode : r_sh_mode;

  // Stage 1: offsets from centre plus config snapshot
  logic signed [11:0] r1_dx, r1_dy;
  logic [15:0]        r1_rgb;
  logic               r1_valid, r1_en;
  logic [9:0]         r1_cx, r1_cy;
  logic [7:0]         r1_rad;
  logic [1:0]         r1_shift, r1_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_dx    <= '0;
      r1_dy    <= '0;
      r1_rgb   <= '0;
      r1_valid <= 1'b0;
      r1_en    <= 1'b0;
      r1_cx    <= '0;
      r1_cy    <= '0;
      r1_rad   <= '0;
      r1_shift <= '0;
      r1_mode  <= '0;
    end else begin
      r1_dx    <= {2'b00, x_local} - {2'b00, w_cx};
      r1_dy    <= {2'b00, y_local} - {2'b00, w_cy};
      r1_rgb   <= rgb565_in;
      r1_valid <= pixel_valid_in;
      r1_en    <= w_en;
      r1_cx    <= w_cx;
      r1_cy    <= w_cy;
      r1_rad   <= w_rad;
      r1_shift <= w_shift;
      r1_mode  <= w_mode;
    end
  end

  // Division by 2^s rounding toward zero, so the zoom is symmetric about the centre
  function automatic logic signed [11:0] f_div(input logic signed [11:0] d,
                                               input logic [1:0] s);
    logic signed [11:0] bias;
    logic signed [11:0] t;
    bias = d[11] ? $signed((12'd1 << s) - 12'd1) : 12'sd0;
    t    = d + bias;
    return t >>> s;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_clamp(input logic signed [12:0] v,
                                                    input int maxv);
    if (v < 13'sd0)
      return '0;
    else if (v > $signed(13'(maxv)))
      return ADDR_WIDTH'(maxv);
    else
      return ADDR_WIDTH'(v);
  endfunction

  logic [11:0]            w_adx, w_ady;
  logic [23:0]            w_dist, w_rad2;
  logic                   w_inside;
  logic signed [11:0]     w_offx, w_offy;
  logic signed [12:0]     w_sx, w_sy;
  logic [ADDR_WIDTH-1:0]  w_sxc, w_syc, w_addr;
  logic                   w_rd;

  assign w_adx    = r1_dx[11] ? 12'(-r1_dx) : r1_dx;
  assign w_ady    = r1_dy[11] ? 12'(-r1_dy) : r1_dy;
  assign w_dist   = 24'(w_adx) * 24'(w_adx) + 24'(w_ady) * 24'(w_ady);
  assign w_rad2   = 24'(r1_rad) * 24'(r1_rad);
  assign w_inside = (w_dist <= w_rad2);
  assign w_offx   = f_div(r1_dx, r1_shift);
  assign w_offy   = f_div(r1_dy, r1_shift);
  assign w_sx     = $signed({3'b000, r1_cx}) + $signed({w_offx[11], w_offx});
  assign w_sy     = $signed({3'b000, r1_cy}) + $signed({w_offy[11], w_offy});
  assign w_sxc    = f_clamp(w_sx, IMG_WIDTH - 1);
  assign w_syc    = f_clamp(w_sy, IMG_HEIGHT - 1);
  assign w_addr   = ADDR_WIDTH'(w_syc * ADDR_WIDTH'(IMG_WIDTH) + w_sxc);
  assign w_rd     = r1_valid & r1_en & w_inside;

  // Stage 2 and delay line aligning pixel context with frame_buffer_data
  logic [FB_LATENCY-1:0] r_dl_valid, r_dl_inside, r_dl_en;
  logic [1:0]            r_dl_mode [FB_LATENCY];
  logic [15:0]           r_dl_rgb  [FB_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      read_addr   <= '0;
      read_en     <= 1'b0;
      r_dl_valid  <= '0;
      r_dl_inside <= '0;
      r_dl_en     <= '0;
      for (int i = 0; i < FB_LATENCY; i++) begin
        r_dl_mode[i] <= '0;
        r_dl_rgb[i]  <= '0;
      end
    end else begin
      read_en <= w_rd;
      if (w_rd)
        read_addr <= w_addr;
      r_dl_valid[0]  <= r1_valid;
      r_dl_inside[0] <= w_inside;
      r_dl_en[0]     <= r1_en;
      r_dl_mode[0]   <= r1_mode;
      r_dl_rgb[0]    <= r1_rgb;
      for (int i = 1; i < FB_LATENCY; i++) begin
        r_dl_valid[i]  <= r_dl_valid[i-1];
        r_dl_inside[i] <= r_dl_inside[i-1];
        r_dl_en[i]     <= r_dl_en[i-1];
        r_dl_mode[i]   <= r_dl_mode[i-1];
        r_dl_rgb[i]    <= r_dl_rgb[i-1];
      end
    end
  end

  logic [15:0] w_live, w_pix;
  assign w_live = r_dl_rgb[c_LAST];

  always_comb begin
    w_pix = w_live;
    if (!r_dl_en[c_LAST]) begin
      w_pix = w_live;
    end else if (r_dl_inside[c_LAST]) begin
      w_pix = frame_buffer_data;
    end else begin
      case (r_dl_mode[c_LAST])
        2'd0:    w_pix = {1'b0, w_live[15:12], 1'b0, w_live[10:6], 1'b0, w_live[4:1]};
        2'd1:    w_pix = 16'h0000;
        2'd2:    w_pix = w_live;
        default: w_pix = {2'b00, w_live[15:13], 2'b00, w_live[10:7], 2'b00, w_live[4:2]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid_out <= 1'b0;
      rgb565_out      <= '0;
    end else begin
      pixel_valid_out <= r_dl_valid[c_LAST];
      if (r_dl_valid[c_LAST])
        rgb565_out <= w_pix;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radial_zoom_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_radial_zoom_filter
// Brief    : Directed bench for radial_zoom_filter at FB_LATENCY 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radial_zoom_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_start, pvi, fen;
  logic [9:0]  x, y, cx, cy;
  logic [15:0] rgb_in;
  logic [7:0]  rad;
  logic [1:0]  sh, mode;

  logic [14:0] ra1, ra3;
  logic        re1, re3, pvo1, pvo3;
  logic [15:0] out1, out3, fb1, fb3, p1, p2;

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] fbf(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  // Frame buffer models: data at ra registered L cycles earlier
  assign fb1 = fbf(ra1);
  always @(posedge clk) begin
    p1 <= fbf(ra3);
    p2 <= p1;
  end
  assign fb3 = p2;

  radial_zoom_filter #(.FB_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid_in(pvi),
    .x_local(x), .y_local(y), .rgb565_in(rgb_in), .filter_en(fen),
    .cfg_center_x(cx), .cfg_center_y(cy), .cfg_radius(rad),
    .cfg_zoom_shift(sh), .cfg_outside_mode(mode),
    .read_addr(ra1), .read_en(re1), .frame_buffer_data(fb1),
    .pixel_valid_out(pvo1), .rgb565_out(out1));

  radial_zoom_filter #(.FB_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid_in(pvi),
    .x_local(x), .y_local(y), .rgb565_in(rgb_in), .filter_en(fen),
    .cfg_center_x(cx), .cfg_center_y(cy), .cfg_radius(rad),
    .cfg_zoom_shift(sh), .cfg_outside_mode(mode),
    .read_addr(ra3), .read_en(re3), .frame_buffer_data(fb3),
    .pixel_valid_out(pvo3), .rgb565_out(out3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic e, input logic [9:0] ccx, input logic [9:0] ccy,
                         input logic [7:0] r, input logic [1:0] s, input logic [1:0] m);
    fen = e; cx = ccx; cy = ccy; rad = r; sh = s; mode = m;
  endtask

  task automatic fs_pulse();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input logic fs, input logic [9:0] px,
                     input logic [9:0] py, input logic [15:0] prgb, input logic exp_re,
                     input logic [14:0] exp_addr, input logic [15:0] exp_out);
    @(negedge clk);
    frame_start = fs; pvi = 1'b1; x = px; y = py; rgb_in = prgb;
    @(negedge clk);
    frame_start = 1'b0; pvi = 1'b0;
    @(negedge clk);
    chk({tag, ".read_en"}, 32'(re1), 32'(exp_re));
    if (exp_re) chk({tag, ".read_addr"}, 32'(ra1), 32'(exp_addr));
    chk({tag, ".early_valid"}, 32'(pvo1), 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(pvo1), 32'd1);
    chk({tag, ".rgb"}, 32'(out1), 32'(exp_out));
  endtask

  function automatic logic vin(input int k);
    return (k >= 0) && ((k <= 3) || (k >= 7 && k <= 12));
  endfunction

  logic [15:0] last1, last3;
  logic        ev;

  initial begin
    reset = 1'b1; frame_start = 1'b0; pvi = 1'b0; x = '0; y = '0; rgb_in = '0;
    set_cfg(1'b0, 10'd0, 10'd0, 8'd0, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst.read_en", 32'(re1), 32'd0);
    chk("rst.read_addr", 32'(ra1), 32'd0);
    chk("rst.valid", 32'(pvo1), 32'd0);
    chk("rst.rgb", 32'(out1), 32'd0);
    reset = 1'b0;

    // Default shadow has the filter disabled
    set_cfg(1'b1, 10'd80, 10'd60, 8'd50, 2'd1, 2'd0);
    pix("disabled", 1'b0, 10'd80, 10'd60, 16'h1234, 1'b0, 15'd0, 16'h1234);
    pix("centre", 1'b1, 10'd80, 10'd60, 16'h1234, 1'b1, 15'd9680, fbf(15'd9680));
    pix("left5", 1'b0, 10'd75, 10'd60, 16'h1234, 1'b1, 15'd9678, fbf(15'd9678));
    pix("right5", 1'b0, 10'd85, 10'd60, 16'h1234, 1'b1, 15'd9682, fbf(15'd9682));

    set_cfg(1'b1, 10'd80, 10'd60, 8'd10, 2'd1, 2'd0);
    fs_pulse();
    pix("r10.edge", 1'b0, 10'd90, 10'd60, 16'hFFFF, 1'b1, 15'd9685, fbf(15'd9685));
    pix("r10.mode0", 1'b0, 10'd91, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'h7BEF);
    mode = 2'd1; fs_pulse();
    pix("r10.mode1", 1'b0, 10'd91, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'h0000);
    mode = 2'd2; fs_pulse();
    pix("r10.mode2", 1'b0, 10'd91, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'hFFFF);
    mode = 2'd3; fs_pulse();
    pix("r10.mode3", 1'b0, 10'd91, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'h39E7);

    set_cfg(1'b1, 10'd0, 10'd0, 8'd255, 2'd3, 2'd0);
    fs_pulse();
    pix("corner0", 1'b0, 10'd159, 10'd119, 16'h0F0F, 1'b1, 15'd2259, fbf(15'd2259));
    set_cfg(1'b1, 10'd159, 10'd119, 8'd255, 2'd3, 2'd0);
    fs_pulse();
    pix("corner1", 1'b0, 10'd0, 10'd0, 16'h0F0F, 1'b1, 15'd16940, fbf(15'd16940));

    set_cfg(1'b1, 10'd80, 10'd60, 8'd10, 2'd1, 2'd0);
    fs_pulse();
    rad = 8'd20;
    pix("midframe", 1'b0, 10'd91, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'h7BEF);
    pix("fs_pixel", 1'b1, 10'd91, 10'd60, 16'hFFFF, 1'b1, 15'd9685, fbf(15'd9685));

    rad = 8'd0;
    pix("r0.centre", 1'b1, 10'd80, 10'd60, 16'hFFFF, 1'b1, 15'd9680, fbf(15'd9680));
    pix("r0.next", 1'b0, 10'd81, 10'd60, 16'hFFFF, 1'b0, 15'd0, 16'h7BEF);

    // Stream with bubble, then reset while pixels are in flight
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_cfg(1'b1, 10'd80, 10'd60, 8'd50, 2'd0, 2'd0);
    last1 = '0; last3 = '0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 12) begin
        ev = vin(c - 3);
        if (ev) last1 = fbf(15'(9670 + c - 3));
        chk($sformatf("stream.l1.valid%0d", c), 32'(pvo1), 32'(ev));
        chk($sformatf("stream.l1.rgb%0d", c), 32'(out1), 32'(last1));
        ev = vin(c - 5);
        if (ev) last3 = fbf(15'(9670 + c - 5));
        chk($sformatf("stream.l3.valid%0d", c), 32'(pvo3), 32'(ev));
        chk($sformatf("stream.l3.rgb%0d", c), 32'(out3), 32'(last3));
      end else begin
        chk($sformatf("post_rst.l1.valid%0d", c), 32'(pvo1), 32'd0);
        chk($sformatf("post_rst.l1.rgb%0d", c), 32'(out1), 32'd0);
        chk($sformatf("post_rst.l3.valid%0d", c), 32'(pvo3), 32'd0);
        chk($sformatf("post_rst.l3.rgb%0d", c), 32'(out3), 32'd0);
      end
      reset       = (c == 12);
      frame_start = (c == 0);
      pvi         = (c <= 12) && vin(c);
      x           = 10'(70 + c);
      y           = 10'd60;
      rgb_in      = 16'(c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
